// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) arbiter onto a single-cycle memory; IDLE/ACCESS/RESP per transaction.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is fixed data priority.
module mem_arbiter #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_i,
  input  logic [AWIDTH-1:0] i_addr_i,
  output logic              i_gnt_o,
  output logic              i_rvalid_o,
  output logic              i_err_o,
  output logic [DWIDTH-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  input  logic [2:0]        d_funct3_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic              d_err_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  output logic [2:0]        mem_funct3_o,
  input  logic [DWIDTH-1:0] mem_data_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nxt;
  logic arb, i_win, d_win, grant, acc, resp, mis, src_d, we_q, err_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q, rdata_q;
  logic [2:0] f3_q;
  assign acc  = state == ACCESS;
  assign resp = state == RESP;
  assign arb  = !rst && !acc;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d;
  always_ff @(posedge clk) begin
    if (rst) last_d <= 1'b0;
    else if (grant) last_d <= d_win;
  end
  assign d_win = arb && d_req_i && !(i_req_i && last_d);
`else
  assign d_win = arb && d_req_i;
`endif
  assign i_win = arb && i_req_i && !d_win;
  assign grant = i_win || d_win;
  assign i_gnt_o = i_win;
  assign d_gnt_o = d_win;
  // fetches latch funct3 = word, so one alignment rule covers both sources
  assign mis = (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00) || (f3_q[1:0] == 2'b01 && addr_q[0]);
  always_comb state_nxt = acc ? RESP : grant ? ACCESS : IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      src_d   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        src_d   <= d_win;
        we_q    <= d_win && d_we_i;
        addr_q  <= d_win ? d_addr_i : i_addr_i;
        wdata_q <= d_win ? d_wdata_i : '0;
        f3_q    <= d_win ? d_funct3_i : 3'b010;
      end
      if (acc) begin
        rdata_q <= (mis || we_q) ? '0 : mem_data_i;
        err_q   <= mis;
      end
    end
  end
  assign mem_read_en_o  = acc && !rst && !mis && !we_q;
  assign mem_write_en_o = acc && !rst && !mis && we_q;
  assign mem_addr_o     = acc ? addr_q : '0;
  assign mem_data_o     = acc ? wdata_q : '0;
  assign mem_funct3_o   = acc ? f3_q : 3'b000;
  assign i_rvalid_o = resp && !src_d;
  assign d_rvalid_o = resp && src_d;
  assign i_err_o    = i_rvalid_o && err_q;
  assign d_err_o    = d_rvalid_o && err_q;
  assign i_rdata_o  = i_rvalid_o ? rdata_q : '0;
  assign d_rdata_o  = d_rvalid_o ? rdata_q : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed + random bench for mem_arbiter against a two-slot transaction model.
module tb_mem_arbiter;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic i_req_i = 1'b0, i_gnt_o, i_rvalid_o, i_err_o;
  logic [31:0] i_addr_i = '0, i_rdata_o;
  logic d_req_i = 1'b0, d_we_i = 1'b0, d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] d_addr_i = '0, d_wdata_i = '0, d_rdata_o;
  logic [2:0] d_funct3_i = '0;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
  logic mem_read_en_o, mem_write_en_o;
  logic [2:0] mem_funct3_o;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];

  mem_arbiter #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o), .i_rvalid_o(i_rvalid_o),
    .i_err_o(i_err_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_funct3_i(d_funct3_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_err_o(d_err_o),
    .d_rdata_o(d_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_read_en_o(mem_read_en_o),
    .mem_write_en_o(mem_write_en_o), .mem_funct3_o(mem_funct3_o), .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;
  assign mem_data_i = mem[mem_addr_o[7:2]];

  typedef struct packed {
    logic        d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
  } txn_t;

  int n_cmp = 0, n_bad = 0;
  bit acc_v = 0, rsp_v = 0, rsp_d = 0, rsp_err = 0, last_d = 0, rand_mode = 0;
  logic [31:0] rsp_data = '0;
  txn_t acc = '0;
  int i_left = 0, d_left = 0, d_grants = 0;
  bit order[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit misaligned(input txn_t t);
    if (!t.d) return t.addr[1:0] != 2'b00;
    return (t.f3[1:0] == 2'b10 && t.addr[1:0] != 2'b00) || (t.f3[1:0] == 2'b01 && t.addr[0]);
  endfunction

  task automatic rand_i();
    i_addr_i = 32'h0100_0000 | (32'($urandom_range(0, 63)) << 2);
    if ($urandom_range(0, 7) == 0) i_addr_i[1:0] = 2'($urandom_range(1, 3));
  endtask

  task automatic rand_d();
    logic [2:0] f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    d_we_i     = 1'($urandom_range(0, 1));
    d_funct3_i = f3s[$urandom_range(0, 4)];
    d_addr_i   = 32'h0100_0000 | 32'($urandom_range(0, 255));
    d_wdata_i  = $urandom;
  endtask

  // one clock: check outputs at negedge, advance the model across the edge, then react as requesters
  task automatic cycle();
    bit e_i, e_d, mis, got_i, got_d, w_en, e_wr;
    logic [31:0] w_a, w_d;
    @(negedge clk);
    e_d = !rst && !acc_v && d_req_i && (!i_req_i || !RR || !last_d);
    e_i = !rst && !acc_v && i_req_i && !e_d;
    mis = acc_v && misaligned(acc);
    e_wr = acc_v && !rst && !mis && acc.we;
    chk("i_gnt", i_gnt_o, e_i);
    chk("d_gnt", d_gnt_o, e_d);
    chk("mem_rd", mem_read_en_o, acc_v && !rst && !mis && !acc.we);
    chk("mem_wr", mem_write_en_o, e_wr);
    chk("mem_addr", mem_addr_o, acc_v ? acc.addr : 32'h0);
    chk("mem_f3", mem_funct3_o, acc_v ? acc.f3 : 3'b000);
    if (e_wr) chk("mem_wdata", mem_data_o, acc.wdata);
    chk("i_rvalid", i_rvalid_o, rsp_v && !rsp_d);
    chk("d_rvalid", d_rvalid_o, rsp_v && rsp_d);
    chk("i_err", i_err_o, rsp_v && !rsp_d && rsp_err);
    chk("d_err", d_err_o, rsp_v && rsp_d && rsp_err);
    chk("i_rdata", i_rdata_o, (rsp_v && !rsp_d) ? rsp_data : 32'h0);
    chk("d_rdata", d_rdata_o, (rsp_v && rsp_d) ? rsp_data : 32'h0);
    if (rst) begin
      acc_v = 0; rsp_v = 0; last_d = 0;
    end else begin
      rsp_v = acc_v;
      if (acc_v) begin
        rsp_d    = acc.d;
        rsp_err  = mis;
        rsp_data = (mis || acc.we) ? 32'h0 : ref_mem[acc.addr[7:2]];
        if (!mis && acc.we) ref_mem[acc.addr[7:2]] = acc.wdata;
      end
      acc_v = e_i || e_d;
      if (e_d) acc = '{d: 1'b1, we: d_we_i, addr: d_addr_i, wdata: d_wdata_i, f3: d_funct3_i};
      else if (e_i) acc = '{d: 1'b0, we: 1'b0, addr: i_addr_i, wdata: 32'h0, f3: 3'b010};
      if (e_i || e_d) last_d = e_d;
    end
    got_i = i_gnt_o; got_d = d_gnt_o;
    w_en = mem_write_en_o; w_a = mem_addr_o; w_d = mem_data_o;
    @(posedge clk);
    if (w_en) mem[w_a[7:2]] = w_d;
    #1;
    if (got_i) begin i_left--; order.push_back(1'b0); if (rand_mode) rand_i(); end
    if (got_d) begin d_left--; d_grants++; order.push_back(1'b1); if (rand_mode) rand_d(); end
    if (rand_mode) begin
      if (i_left == 0 && $urandom_range(0, 2) == 0) begin i_left = 1; rand_i(); end
      if (d_left == 0 && $urandom_range(0, 2) == 0) begin d_left = 1; rand_d(); end
      rst = ($urandom_range(0, 63) == 0);
    end
    i_req_i = i_left > 0;
    d_req_i = d_left > 0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic load_d(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3, input int n);
    d_we_i = we; d_addr_i = a; d_wdata_i = wd; d_funct3_i = f3; d_left = n; d_req_i = n > 0;
  endtask

  initial begin
    logic [3:0] seq;
    for (int k = 0; k < 64; k++) begin mem[k] = $urandom; ref_mem[k] = mem[k]; end
    mem[0] = 32'h0050_0093; ref_mem[0] = mem[0];
    mem[8] = 32'h1111_2222; ref_mem[8] = mem[8];
    @(posedge clk); #1;
    run(2);
    rst = 1'b0;
    run(1);
    // fetch of a known instruction word
    i_addr_i = 32'h0100_0000; i_left = 1; i_req_i = 1'b1;
    run(4);
    // word store then fetch from the same address
    load_d(1'b1, 32'h0100_0010, 32'hCAFE_BABE, 3'b010, 1);
    run(4);
    chk("store_mem", mem[4], 32'hCAFE_BABE);
    i_addr_i = 32'h0100_0010; i_left = 1; i_req_i = 1'b1;
    run(4);
    // misaligned halfword load
    load_d(1'b0, 32'h0100_0003, 32'h0, 3'b001, 1);
    run(4);
    // reset while a store is in ACCESS
    load_d(1'b1, 32'h0100_0020, 32'hDEAD_BEEF, 3'b010, 1);
    run(1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(3);
    chk("rst_store_mem", mem[8], 32'h1111_2222);
    // both ports held for four transactions each
    rst = 1'b1; run(1); rst = 1'b0;
    order.delete();
    i_addr_i = 32'h0100_0004; i_left = 4; i_req_i = 1'b1;
    load_d(1'b0, 32'h0100_0008, 32'h0, 3'b010, 4);
    run(8);
    chk("order_len", 32'(order.size()), 32'd4);
    seq = '0;
    for (int k = 0; k < 4 && k < order.size(); k++) seq[3 - k] = order[k];
    chk("grant_order", seq, RR ? 4'b1010 : 4'b1111);
    run(12);
    i_left = 0; d_left = 0; i_req_i = 1'b0; d_req_i = 1'b0;
    run(2);
    // back-to-back loads: one grant every two cycles
    d_grants = 0;
    load_d(1'b0, 32'h0100_000C, 32'h0, 3'b010, 6);
    run(12);
    chk("b2b_grants", 32'(d_grants), 32'd6);
    run(3);
    // random traffic with occasional resets
    rand_mode = 1'b1;
    run(400);
    rand_mode = 1'b0; rst = 1'b0;
    i_left = 0; d_left = 0; i_req_i = 1'b0; d_req_i = 1'b0;
    run(4);
    for (int k = 0; k < 64; k++) chk("final_mem", mem[k], ref_mem[k]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, address width.
REQ-002 SHALL have parameter DWIDTH, default 32, data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have instruction ports: i_req_i in 1; i_addr_i in AWIDTH; i_gnt_o out 1; i_rvalid_o out 1; i_err_o out 1; i_rdata_o out DWIDTH.
REQ-006 SHALL have data ports: d_req_i in 1; d_we_i in 1; d_addr_i in AWIDTH; d_wdata_i in DWIDTH; d_funct3_i in 3; d_gnt_o out 1; d_rvalid_o out 1; d_err_o out 1; d_rdata_o out DWIDTH.
REQ-007 SHALL have memory ports: mem_addr_o out AWIDTH; mem_data_o out DWIDTH; mem_read_en_o out 1; mem_write_en_o out 1; mem_funct3_o out 3; mem_data_i in DWIDTH (combinational read data).

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, RESP; IDLE->ACCESS and RESP->ACCESS on grant; RESP->IDLE with no grant; ACCESS->RESP always.
REQ-009 SHALL arbitrate only in IDLE or RESP; gnt_o is combinational, one-cycle pulse, at most one of i_gnt_o/d_gnt_o high per cycle.
REQ-010 Requester holds req and payload stable until gnt; payload (addr, we, wdata, funct3, source) latched at the granting edge.
REQ-011 Single request pending: that requester granted.
REQ-012 Both pending: winner per Configuration (REQ-021/022).
REQ-013 In ACCESS: mem_addr_o/mem_data_o/mem_funct3_o from latched payload; mem_read_en_o=1 for reads, mem_write_en_o=1 for writes; instruction fetches force funct3 3'b010 and read.
REQ-014 Outside ACCESS: mem_read_en_o=0, mem_write_en_o=0, mem_addr_o=0, mem_data_o=0, mem_funct3_o=0.
REQ-015 Read data: mem_data_i sampled at end of ACCESS into rdata register; RESP cycle drives granted source's rvalid_o=1 and rdata_o; the other source's rdata_o=0.
REQ-016 Writes: d_rvalid_o=1 in RESP with d_rdata_o=0 (write acknowledge).
REQ-017 Latency: gnt in cycle N -> memory access N+1 -> rvalid N+2; back-to-back throughput one transaction per 2 cycles.
REQ-018 Misalignment: data access with funct3[1:0]=2'b10 and addr[1:0]!=0, or funct3[1:0]=2'b01 and addr[0]=1, or fetch with addr[1:0]!=0 -> ACCESS issues no memory enable; RESP gives rvalid_o=1, err_o=1, rdata_o=0.
REQ-019 err_o SHALL be 0 whenever rvalid_o is 0.

Reset
REQ-020 rst high: next state IDLE; all outputs 0 in the following cycle; mem_read_en_o and mem_write_en_o forced 0 combinationally while rst high (an in-flight ACCESS write is dropped, no rvalid issued); gnt_o forced 0 while rst high; round-robin pointer reset to "last winner = instruction".

Configuration
REQ-021 Macro MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests grant the source not granted most recently; pointer updates on every grant.
REQ-022 Macro undefined: fixed priority, data port always wins simultaneous requests; no pointer register.

Verification
REQ-023 Fetch i_addr_i=0x01000000, memory word 0x00500093 -> i_gnt_o cycle N, mem_read_en_o N+1, i_rvalid_o N+2 with i_rdata_o=0x00500093, i_err_o=0.
REQ-024 Store d_we_i=1, d_addr_i=0x01000010, d_wdata_i=0xCAFEBABE, funct3=3'b010 -> mem_write_en_o one cycle, d_rvalid_o=1, d_rdata_o=0; subsequent fetch from 0x01000010 returns 0xCAFEBABE.
REQ-025 Both requests held 4 transactions -> macro undefined: D,D,D,D grants while data held, fetch waits; macro defined: D,I,D,I.
REQ-026 Load funct3=3'b001, d_addr_i=0x01000003 -> no mem enable, d_rvalid_o=1, d_err_o=1, d_rdata_o=0.
REQ-027 rst asserted during ACCESS of store to 0x01000020 -> mem_write_en_o=0 that cycle, no d_rvalid_o, memory word unchanged, FSM IDLE after reset released.
REQ-028 Back-to-back loads held continuously -> d_gnt_o every 2 cycles, rvalid each RESP, no idle gap.
